// File: rtl/pio_seq_pkg.sv
// Shared constants and state types for the PIO pattern sequencer.
package pio_seq_pkg;
  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_DWELL    = 4'd2;
  localparam logic [3:0] REG_DIRECT   = 4'd3;
  localparam logic [3:0] REG_PAT_BASE = 4'd8;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_LOOP    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_IDX_LSB = 8;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} seq_state_t;
  typedef enum logic {IDLE = 1'b0, WR  = 1'b1} arb_state_t;
endpackage

// File: rtl/pio_seq_arbiter.sv
// Arbitrates direct override writes against sequencer steps onto the PIO
// Avalon-MM master port; direct writes win, each write is a WR/IDLE pair.
module pio_seq_arbiter import pio_seq_pkg::*; #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dir_req,
  input  logic [DATA_W-1:0] dir_val,
  input  logic              step_req,
  input  logic              step_drop,
  input  logic [DATA_W-1:0] step_val,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [31:0]       m_writedata
);
  arb_state_t        state_q, state_d;
  logic              dir_pend_q, dir_pend_d, step_pend_q, step_pend_d;
  logic              dir_pend_eff, step_pend_eff;
  logic [DATA_W-1:0] dir_val_q, dir_val_d, data_q, data_d;

  // Pending flags clear at issue so a request landing during WR is kept.
  always_comb begin
    dir_pend_eff  = dir_pend_q | dir_req;
    step_pend_eff = (step_pend_q | step_req) & ~step_drop;
    dir_val_d     = dir_req ? dir_val : dir_val_q;
    state_d       = state_q;
    data_d        = data_q;
    dir_pend_d    = dir_pend_eff;
    step_pend_d   = step_pend_eff;
    if (state_q == IDLE) begin
      if (dir_pend_eff) begin
        state_d    = WR;
        data_d     = dir_val_d;
        dir_pend_d = 1'b0;
      end else if (step_pend_eff) begin
        state_d     = WR;
        data_d      = step_val;
        step_pend_d = 1'b0;
      end
    end else if (!m_waitrequest) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_pend_q  <= 1'b0;
      step_pend_q <= 1'b0;
      dir_val_q   <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      dir_pend_q  <= dir_pend_d;
      step_pend_q <= step_pend_d;
      dir_val_q   <= dir_val_d;
      data_q      <= data_d;
    end
  end

  assign busy         = (state_q == WR);
  assign m_chipselect = (state_q == WR);
  assign m_write_n    = (state_q != WR);
  assign m_address    = 2'd0;
  assign m_writedata  = 32'(data_q);
endmodule

// File: rtl/pio_pattern_sequencer.sv
// Plays a CPU-programmed pattern table onto an 8-bit PIO with a dwell timer.
// Define PIO_SEQ_IRQ_EN to add the level irq output (DONE & CTRL.IRQ_EN).
module pio_pattern_sequencer import pio_seq_pkg::*; #(
  parameter int NUM_PAT = 4,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
`ifdef PIO_SEQ_IRQ_EN
  output logic        irq,
`endif
  input  logic        m_waitrequest
);
  localparam int IDX_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;

  seq_state_t                     seq_q, seq_d;
  logic                           loop_q, loop_d, done_q, done_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [DWELL_W-1:0]             cnt_q, cnt_d, dwell_q, dwell_d, dwell_eff;
  logic [NUM_PAT-1:0][DATA_W-1:0] pat_q, pat_d;
  logic                           irq_en, busy, step_req, step_drop;
  logic                           wr_en, ctrl_wr, dwell_wr, dir_wr, pat_wr, pat_hit;
  logic [3:0]                     pat_off;
  logic [IDX_W-1:0]               pat_sel;
  logic                           unused_ok;

  assign wr_en     = s_chipselect & ~s_write_n;
  assign pat_off   = s_address - REG_PAT_BASE;
  assign pat_hit   = (s_address >= REG_PAT_BASE) && (pat_off < 4'(NUM_PAT));
  assign pat_sel   = pat_off[IDX_W-1:0];
  assign ctrl_wr   = wr_en && (s_address == REG_CTRL);
  assign dwell_wr  = wr_en && (s_address == REG_DWELL);
  assign dir_wr    = wr_en && (s_address == REG_DIRECT);
  assign pat_wr    = wr_en && pat_hit;
  assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign unused_ok = ^s_writedata;

`ifdef PIO_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;
  assign irq_en = irq_en_q;
  assign irq    = done_q & irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  // A CTRL write pre-empts the dwell terminal count in the same cycle.
  always_comb begin
    seq_d     = seq_q;
    loop_d    = loop_q;
    done_d    = done_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    pat_d     = pat_q;
    step_req  = 1'b0;
    step_drop = 1'b0;
`ifdef PIO_SEQ_IRQ_EN
    irq_en_d  = irq_en_q;
`endif
    if (dwell_wr) dwell_d = s_writedata[DWELL_W-1:0];
    if (pat_wr)   pat_d[pat_sel] = s_writedata[DATA_W-1:0];
    if (ctrl_wr) begin
      loop_d = s_writedata[CTRL_LOOP];
      done_d = 1'b0;
`ifdef PIO_SEQ_IRQ_EN
      irq_en_d = s_writedata[CTRL_IRQ_EN];
`endif
      if (!s_writedata[CTRL_RUN]) begin
        seq_d     = STOP;
        step_drop = 1'b1;
      end else if (seq_q == STOP) begin
        seq_d    = RUN;
        idx_d    = '0;
        cnt_d    = dwell_eff;
        step_req = 1'b1;
      end
    end else if (seq_q == RUN) begin
      if (cnt_q > DWELL_W'(1)) begin
        cnt_d = cnt_q - 1'b1;
      end else if (loop_q || (idx_q != IDX_W'(NUM_PAT - 1))) begin
        idx_d    = idx_q + 1'b1;
        cnt_d    = dwell_eff;
        step_req = 1'b1;
      end else begin
        seq_d  = STOP;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q   <= STOP;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= DWELL_W'(1);
      pat_q   <= '0;
`ifdef PIO_SEQ_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      seq_q   <= seq_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      pat_q   <= pat_d;
`ifdef PIO_SEQ_IRQ_EN
      irq_en_q <= irq_en_d;
`endif
    end
  end

  always_comb begin
    s_readdata = '0;
    if (pat_hit) begin
      s_readdata[DATA_W-1:0] = pat_q[pat_sel];
    end else begin
      case (s_address)
        REG_CTRL: begin
          s_readdata[CTRL_RUN]    = (seq_q == RUN);
          s_readdata[CTRL_LOOP]   = loop_q;
          s_readdata[CTRL_IRQ_EN] = irq_en;
        end
        REG_STATUS: begin
          s_readdata[STAT_BUSY]          = busy;
          s_readdata[STAT_DONE]          = done_q;
          s_readdata[STAT_IDX_LSB +: 3]  = 3'(idx_q);
        end
        REG_DWELL: s_readdata[DWELL_W-1:0] = dwell_q;
        default: ;
      endcase
    end
  end

  // Pattern is sampled from the next-state index so the issue sees the
  // freshly advanced step in the same cycle it is requested.
  pio_seq_arbiter #(.DATA_W(DATA_W)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .dir_req       (dir_wr),
    .dir_val       (s_writedata[DATA_W-1:0]),
    .step_req      (step_req),
    .step_drop     (step_drop),
    .step_val      (pat_q[idx_d]),
    .m_waitrequest (m_waitrequest),
    .busy          (busy),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata)
  );
endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Scoreboard bench: stimulus pushes expected PIO writes (value, cycle), a
// monitor pops and checks each completed master write.
module tb_pio_pattern_sequencer;
  logic        clk, reset;
  logic [3:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n, m_waitrequest;
  logic [31:0] m_writedata;
`ifdef PIO_SEQ_IRQ_EN
  logic        irq;
`endif

  pio_pattern_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .s_address     (s_address),
    .s_chipselect  (s_chipselect),
    .s_write_n     (s_write_n),
    .s_writedata   (s_writedata),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
`ifdef PIO_SEQ_IRQ_EN
    .irq           (irq),
`endif
    .m_waitrequest (m_waitrequest)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // All stimulus tasks are entered at a negedge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, output int c);
    s_address    = a;
    s_writedata  = d;
    s_chipselect = 1'b1;
    s_write_n    = 1'b0;
    c            = cyc;
    @(negedge clk);
    s_chipselect = 1'b0;
    s_write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    s_address    = a;
    s_chipselect = 1'b1;
    s_write_n    = 1'b1;
    #1;
    chk(nm, s_readdata, exp);
    s_chipselect = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pio_unexpected: got data 0x%0h at cycle %0d, none expected", m_writedata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pio_data", m_writedata, e.data);
        chk("pio_cycle", 32'(cyc), 32'(e.cyc));
        chk("pio_addr", 32'(m_address), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2;
    reset = 1'b1; s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1;
    s_writedata = '0; m_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_cs", 32'(m_chipselect), 32'd0);
    chk("rst_wn", 32'(m_write_n), 32'd1);
    chk("rst_wdata", m_writedata, 32'd0);
    rd(4'd0, 32'h0, "rst_ctrl");
    rd(4'd1, 32'h0, "rst_status");
    @(negedge clk);
    rd(4'd2, 32'h1, "rst_dwell");
    rd(4'd3, 32'h0, "rst_direct");
    rd(4'd8, 32'h0, "rst_pat0");
    rd(4'd5, 32'h0, "rst_unmapped");
    @(negedge clk);

    // one-shot sequence, dwell 4
    wr(4'd8,  32'h01, c); wr(4'd9,  32'h02, c);
    wr(4'd10, 32'h04, c); wr(4'd11, 32'h08, c);
    wr(4'd2,  32'd4, c);
    wr(4'd5,  32'hFF, c);
    rd(4'd10, 32'h04, "pat2_readback");
    rd(4'd5, 32'h0, "unmapped_write_ignored");
    wr(4'd0, 32'h1, c);
    push(32'h01, c + 1); push(32'h02, c + 5); push(32'h04, c + 9); push(32'h08, c + 13);
    wait_cyc(c + 16);
    rd(4'd1, 32'h300, "last_dwell_not_done");
    @(negedge clk);
    rd(4'd1, 32'h302, "done_status");
    rd(4'd0, 32'h0, "done_ctrl");
    chk("pio_hold_last", m_writedata, 32'h08);

    // loop mode, then stop mid-dwell
    @(negedge clk);
    wr(4'd0, 32'h3, c);
    rd(4'd0, 32'h3, "loop_ctrl");
    push(32'h01, c + 1); push(32'h02, c + 5); push(32'h04, c + 9);
    push(32'h08, c + 13); push(32'h01, c + 17);
    wait_cyc(c + 19);
    wr(4'd0, 32'h0, c2);
    wait_cyc(c + 40);
    rd(4'd1, 32'h000, "stopped_status");

    // direct write colliding with a step
    wr(4'd0, 32'h3, c);
    push(32'h01, c + 1); push(32'h02, c + 5);
    wait_cyc(c + 8);
    wr(4'd3, 32'hA5, c2);
    push(32'hA5, c2 + 1); push(32'h04, c2 + 3); push(32'h08, c2 + 5);
    wait_cyc(c2 + 6);
    wr(4'd0, 32'h0, c2);
    repeat (10) @(negedge clk);
    chk("pio_after_direct", m_writedata, 32'h08);

    // 5-cycle stall on the first write; step during the stall follows
    wr(4'd0, 32'h1, c);
    push(32'h01, c + 6); push(32'h02, c + 8); push(32'h04, c + 10); push(32'h08, c + 13);
    for (int k = 0; k < 5; k++) begin
      m_waitrequest = 1'b1;
      rd(4'd1, (k < 4) ? 32'h001 : 32'h101, "stall_busy");
      chk("stall_cs", {31'd0, m_chipselect & ~m_write_n}, 32'd1);
      chk("stall_data", m_writedata, 32'h01);
      @(negedge clk);
    end
    m_waitrequest = 1'b0;
    wait_cyc(c + 20);
    rd(4'd1, 32'h302, "stall_done_status");

    // DWELL=0 acts as 1: steps coalesce, writes separated by IDLE
    wr(4'd2, 32'd0, c);
    rd(4'd2, 32'd0, "dwell_zero_readback");
    wr(4'd0, 32'h1, c);
    push(32'h01, c + 1); push(32'h04, c + 3); push(32'h08, c + 5);
    wait_cyc(c + 8);
    rd(4'd1, 32'h302, "dwell0_done_status");

    // reset while a write is stalled on the bus
    wr(4'd0, 32'h1, c);
    m_waitrequest = 1'b1;
    #1;
    chk("pre_reset_cs", 32'(m_chipselect), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_cs", 32'(m_chipselect), 32'd0);
    chk("async_rst_wn", 32'(m_write_n), 32'd1);
    chk("async_rst_wdata", m_writedata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    rd(4'd1, 32'h0, "post_rst_status");
    rd(4'd2, 32'h1, "post_rst_dwell");
    rd(4'd9, 32'h0, "post_rst_pat1");
    @(negedge clk);

`ifdef PIO_SEQ_IRQ_EN
    // irq follows DONE when IRQ_EN set, clears on next CTRL write
    wr(4'd0, 32'h5, c);
    push(32'h00, c + 1); push(32'h00, c + 3); push(32'h00, c + 5);
    wait_cyc(c + 4);
    #1 chk("irq_before_done", 32'(irq), 32'd0);
    wait_cyc(c + 5);
    #1 chk("irq_on_done", 32'(irq), 32'd1);
    rd(4'd0, 32'h4, "irq_ctrl_readback");
    wait_cyc(c + 7);
    wr(4'd0, 32'h0, c2);
    #1 chk("irq_cleared", 32'(irq), 32'd0);
`endif

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
